dmem_responder: RTL and testbench
=================================

# dmem_responder

Memory-side responder for the core's data-memory port: accepts one load/store request at a time over a valid/ready handshake, inserts a configurable number of wait states, performs the byte/halfword/word access on an internal word-organised array, and returns a response over a second valid/ready handshake. It replaces the single-cycle data memory once the pipeline moves to stall-on-memory. Misaligned and malformed requests are flagged and never touch the array.

## Interface

- ADDR_W, 16, byte-address width; array depth = 2^(ADDR_W-2) 32-bit words
- WAIT_CYCLES, 2, wait states inserted before each array access (0 legal)
- CLK  input  1  clock; all state updates on posedge
- RST_N  input  1  synchronous, active-low reset; one clock, reset is synchronous and active-low
- REQ_VALID  input  1  request present
- REQ_READY  output  1  responder can accept a request
- REQ_WEN  input  1  store
- REQ_RDEN  input  1  load
- REQ_BYTE_SEL  input  2  00 byte, 01 halfword, 10 word, 11 illegal
- REQ_SIGN  input  1  1 = sign-extend loads, 0 = zero-extend
- REQ_ADDR  input  ADDR_W  byte address
- REQ_WDATA  input  32  store data, right-aligned (byte in [7:0], half in [15:0])
- RSP_VALID  output  1  response present
- RSP_READY  input  1  consumer accepts response
- RSP_RDATA  output  32  load data, extended; 0 for stores, no-ops, errors
- RSP_ERR  output  1  request was misaligned or malformed
- BUSY  output  1  high whenever state is not IDLE

## Operation

- States: IDLE, WAIT, RESP. Reset -> IDLE.
- IDLE: REQ_READY=1. On REQ_VALID&REQ_READY capture all REQ_* fields into holding registers.
  - Error if: BYTE_SEL=11; half with ADDR[0]=1; word with ADDR[1:0]!=00; WEN and RDEN both 1. Error -> RESP with RSP_ERR=1, RSP_RDATA=0, no array access.
  - Otherwise -> WAIT, wait counter loaded with WAIT_CYCLES.
- WAIT: if counter!=0 decrement and stay; if counter==0 perform access at this edge and -> RESP.
  - Word index = ADDR[ADDR_W-1:2].
  - Store: write only addressed lanes. Byte: lane ADDR[1:0] <= WDATA[7:0]. Half: lanes {ADDR[1],0},{ADDR[1],1} <= WDATA[15:0]. Word: all lanes. Other lanes unchanged.
  - Load: selected byte/half shifted to bit 0 (shift = 8*ADDR[1:0]), extended per SIGN to 32 bits, registered into RSP_RDATA.
  - WEN=RDEN=0: no-op, RSP_RDATA=0, RSP_ERR=0.
- RESP: RSP_VALID=1; RSP_RDATA/RSP_ERR held stable until RSP_VALID&RSP_READY; then -> IDLE, RSP_VALID, RSP_ERR and RSP_RDATA clear to 0.
- One outstanding transaction; REQ_READY=0 in WAIT and RESP.
- Array contents are not reset and are not cleared by RST_N.

## Timing

- Reset values: REQ_READY=1 after reset cycle, RSP_VALID=0, RSP_RDATA=0, RSP_ERR=0, BUSY=0, counter=0. During the reset cycle REQ_READY=0.
- Accept in cycle 0 -> WAIT in cycles 1..WAIT_CYCLES+1 -> RSP_VALID first high in cycle WAIT_CYCLES+2 (cycle 2 when WAIT_CYCLES=0).
- Error request: RSP_VALID high in cycle 1.
- Response consumed in cycle k -> REQ_READY high in cycle k+1; minimum request spacing = WAIT_CYCLES+3 cycles.
- RSP_VALID never deasserts without RSP_READY (except by reset).
- RST_N low in any state: next edge -> IDLE, outputs to reset values; a store in WAIT whose access edge coincides with reset is NOT written; pending response discarded.
- REQ_* changes while not in IDLE are ignored.

## Test plan

- Reset: hold RST_N=0 two cycles -> RSP_VALID=0, RSP_ERR=0, RSP_RDATA=0, BUSY=0; REQ_READY=1 first cycle after release.
- Word store 0x11223344 to 0x0010, then word load 0x0010 (WAIT_CYCLES=2) -> RSP_VALID in cycle 4 after each accept, load RSP_RDATA=0x11223344, RSP_ERR=0.
- Byte store 0xA5 to 0x0013, then lb 0x0013 -> 0xFFFFFFA5; lbu -> 0x000000A5; lh signed 0x0012 -> 0xFFFFA522; word load 0x0010 -> 0xA5223344.
- Half load 0x0011 and word store 0x0012 -> RSP_ERR=1, RSP_RDATA=0, RSP_VALID in cycle 1; subsequent word load 0x0010 still 0xA5223344.
- Backpressure: load with RSP_READY=0 for 3 cycles after RSP_VALID -> RSP_VALID, RSP_RDATA stable, REQ_READY=0, new REQ_VALID ignored; RSP_READY=1 -> REQ_READY=1 next cycle.
- Reset mid-op: word store 0xDEADBEEF to 0x0010, RST_N=0 in its last WAIT cycle -> no write; word load 0x0010 after reset returns 0xA5223344.

Source files
------------

// File: rtl/dmem_responder.sv
// Data-memory responder: one load/store at a time over valid/ready, with
// configurable wait states before the access on a word-organised byte-lane array.
module dmem_responder #(
    parameter int unsigned ADDR_W      = 16,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              REQ_VALID,
    output logic              REQ_READY,
    input  logic              REQ_WEN,
    input  logic              REQ_RDEN,
    input  logic [1:0]        REQ_BYTE_SEL,
    input  logic              REQ_SIGN,
    input  logic [ADDR_W-1:0] REQ_ADDR,
    input  logic [31:0]       REQ_WDATA,
    output logic              RSP_VALID,
    input  logic              RSP_READY,
    output logic [31:0]       RSP_RDATA,
    output logic              RSP_ERR,
    output logic              BUSY
);
    localparam int unsigned IDX_W = ADDR_W - 2;
    localparam int unsigned DEPTH = 1 << IDX_W;
    localparam int unsigned CNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               wen_q, wen_d, rden_q, rden_d, sign_q, sign_d;
    logic [1:0]         sel_q, sel_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [31:0]        wdata_q, wdata_d;
    logic               req_ready_q, req_ready_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic               rsp_err_q, rsp_err_d;
    logic [31:0]        rsp_rdata_q, rsp_rdata_d;
    logic               busy_q, busy_d;

    logic [31:0]        mem [DEPTH];
    logic [31:0]        mem_rd, mem_sh, load_val;
    logic               mem_we;
    logic [3:0]         mem_be;
    logic [31:0]        mem_wdata;
    logic               accept, req_err;

    assign accept = REQ_VALID & req_ready_q;
    assign req_err = (REQ_BYTE_SEL == 2'b11)
                   | ((REQ_BYTE_SEL == 2'b01) & REQ_ADDR[0])
                   | ((REQ_BYTE_SEL == 2'b10) & (REQ_ADDR[1:0] != 2'b00))
                   | (REQ_WEN & REQ_RDEN);

    // State register
    always_ff @(posedge CLK) begin
        if (!RST_N) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (accept) state_d = req_err ? S_RESP : S_WAIT;
            S_WAIT:  if (cnt_q == '0) state_d = S_RESP;
            S_RESP:  if (RSP_READY) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Load alignment and extension from the addressed word
    always_comb begin
        mem_rd = mem[addr_q[ADDR_W-1:2]];
        mem_sh = mem_rd >> {addr_q[1:0], 3'b000};
        case (sel_q)
            2'b00:   load_val = {{24{sign_q & mem_sh[7]}}, mem_sh[7:0]};
            2'b01:   load_val = {{16{sign_q & mem_sh[15]}}, mem_sh[15:0]};
            default: load_val = mem_rd;
        endcase
    end

    // Datapath and registered-output next values
    always_comb begin
        cnt_d       = cnt_q;
        wen_d       = wen_q;
        rden_d      = rden_q;
        sel_d       = sel_q;
        sign_d      = sign_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        req_ready_d = (state_d == S_IDLE);
        rsp_valid_d = (state_d == S_RESP);
        busy_d      = (state_d != S_IDLE);
        mem_we      = 1'b0;
        mem_be      = 4'b0000;
        mem_wdata   = 32'h0;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    wen_d       = REQ_WEN;
                    rden_d      = REQ_RDEN;
                    sel_d       = REQ_BYTE_SEL;
                    sign_d      = REQ_SIGN;
                    addr_d      = REQ_ADDR;
                    wdata_d     = REQ_WDATA;
                    cnt_d       = CNT_W'(WAIT_CYCLES);
                    rsp_err_d   = req_err;
                    rsp_rdata_d = 32'h0;
                end
            end
            S_WAIT: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else if (wen_q) begin
                    mem_we      = RST_N;
                    rsp_rdata_d = 32'h0;
                    case (sel_q)
                        2'b00: begin
                            mem_be    = 4'b0001 << addr_q[1:0];
                            mem_wdata = {4{wdata_q[7:0]}};
                        end
                        2'b01: begin
                            mem_be    = addr_q[1] ? 4'b1100 : 4'b0011;
                            mem_wdata = {2{wdata_q[15:0]}};
                        end
                        default: begin
                            mem_be    = 4'b1111;
                            mem_wdata = wdata_q;
                        end
                    endcase
                end else begin
                    rsp_rdata_d = rden_q ? load_val : 32'h0;
                end
            end
            S_RESP: begin
                if (RSP_READY) begin
                    rsp_rdata_d = 32'h0;
                    rsp_err_d   = 1'b0;
                end
            end
            default: ;
        endcase
    end

    // Control and output registers
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            cnt_q       <= '0;
            wen_q       <= 1'b0;
            rden_q      <= 1'b0;
            sel_q       <= 2'b00;
            sign_q      <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= 32'h0;
            req_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= 32'h0;
            busy_q      <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            wen_q       <= wen_d;
            rden_q      <= rden_d;
            sel_q       <= sel_d;
            sign_q      <= sign_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
            busy_q      <= busy_d;
        end
    end

    // Array is deliberately not reset; the write enable is already gated by reset
    always_ff @(posedge CLK) begin
        if (mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (mem_be[b]) mem[addr_q[ADDR_W-1:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
            end
        end
    end

    assign REQ_READY = req_ready_q;
    assign RSP_VALID = rsp_valid_q;
    assign RSP_RDATA = rsp_rdata_q;
    assign RSP_ERR   = rsp_err_q;
    assign BUSY      = busy_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed self-checking bench for dmem_responder (ADDR_W=16, WAIT_CYCLES=2).
module tb_dmem_responder;
    localparam int unsigned ADDR_W      = 16;
    localparam int unsigned WAIT_CYCLES = 2;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic              req_wen = 1'b0;
    logic              req_rden = 1'b0;
    logic [1:0]        req_byte_sel = 2'b00;
    logic              req_sign = 1'b0;
    logic [ADDR_W-1:0] req_addr = '0;
    logic [31:0]       req_wdata = 32'h0;
    logic              rsp_valid;
    logic              rsp_ready = 1'b1;
    logic [31:0]       rsp_rdata;
    logic              rsp_err;
    logic              busy;

    int checks = 0;
    int errors = 0;

    dmem_responder #(.ADDR_W(ADDR_W), .WAIT_CYCLES(WAIT_CYCLES)) dut (
        .CLK(clk), .RST_N(rst_n),
        .REQ_VALID(req_valid), .REQ_READY(req_ready),
        .REQ_WEN(req_wen), .REQ_RDEN(req_rden), .REQ_BYTE_SEL(req_byte_sel),
        .REQ_SIGN(req_sign), .REQ_ADDR(req_addr), .REQ_WDATA(req_wdata),
        .RSP_VALID(rsp_valid), .RSP_READY(rsp_ready), .RSP_RDATA(rsp_rdata),
        .RSP_ERR(rsp_err), .BUSY(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic wen, input logic rden, input logic [1:0] sel,
                         input logic sign, input logic [15:0] addr, input logic [31:0] wdata);
        req_valid    = 1'b1;
        req_wen      = wen;
        req_rden     = rden;
        req_byte_sel = sel;
        req_sign     = sign;
        req_addr     = addr;
        req_wdata    = wdata;
    endtask

    // Full transaction with RSP_READY held high; latency counted from the accept edge
    task automatic xact(input string tag, input logic wen, input logic rden,
                        input logic [1:0] sel, input logic sign, input logic [15:0] addr,
                        input logic [31:0] wdata, input int exp_lat,
                        input logic [31:0] exp_rdata, input logic exp_err);
        int n;
        chk({tag, "/ready_before"}, 32'(req_ready), 32'd1);
        drive(wen, rden, sel, sign, addr, wdata);
        tick();
        req_valid = 1'b0;
        chk({tag, "/ready_after_accept"}, 32'(req_ready), 32'd0);
        chk({tag, "/busy"}, 32'(busy), 32'd1);
        n = 1;
        while (!rsp_valid && n < 20) begin
            tick();
            n++;
        end
        chk({tag, "/latency"}, 32'(n), 32'(exp_lat));
        chk({tag, "/rdata"}, rsp_rdata, exp_rdata);
        chk({tag, "/err"}, 32'(rsp_err), 32'(exp_err));
        tick();
        chk({tag, "/valid_clear"}, 32'(rsp_valid), 32'd0);
        chk({tag, "/ready_again"}, 32'(req_ready), 32'd1);
        chk({tag, "/rdata_clear"}, rsp_rdata, 32'h0);
    endtask

    initial begin
        logic [31:0] held;
        int n;

        // Reset held for two cycles
        repeat (2) tick();
        chk("rst/valid", 32'(rsp_valid), 32'd0);
        chk("rst/err", 32'(rsp_err), 32'd0);
        chk("rst/rdata", rsp_rdata, 32'h0);
        chk("rst/busy", 32'(busy), 32'd0);
        chk("rst/ready_low", 32'(req_ready), 32'd0);
        rst_n = 1'b1;
        tick();
        chk("rst/ready_high", 32'(req_ready), 32'd1);

        // Word store and load
        xact("sw_10", 1, 0, 2'b10, 0, 16'h0010, 32'h11223344, 4, 32'h0, 0);
        xact("lw_10", 0, 1, 2'b10, 0, 16'h0010, 32'h0, 4, 32'h11223344, 0);

        // Byte store with junk in upper data bits, then sub-word loads
        xact("sb_13", 1, 0, 2'b00, 0, 16'h0013, 32'h123456A5, 4, 32'h0, 0);
        xact("lb_13", 0, 1, 2'b00, 1, 16'h0013, 32'h0, 4, 32'hFFFFFFA5, 0);
        xact("lbu_13", 0, 1, 2'b00, 0, 16'h0013, 32'h0, 4, 32'h000000A5, 0);
        xact("lh_12", 0, 1, 2'b01, 1, 16'h0012, 32'h0, 4, 32'hFFFFA522, 0);
        xact("lhu_10", 0, 1, 2'b01, 0, 16'h0010, 32'h0, 4, 32'h00003344, 0);
        xact("lb_10", 0, 1, 2'b00, 1, 16'h0010, 32'h0, 4, 32'h00000044, 0);
        xact("lw_10b", 0, 1, 2'b10, 0, 16'h0010, 32'h0, 4, 32'hA5223344, 0);

        // Malformed and misaligned requests
        xact("lh_11_err", 0, 1, 2'b01, 1, 16'h0011, 32'h0, 1, 32'h0, 1);
        xact("sw_12_err", 1, 0, 2'b10, 0, 16'h0012, 32'hFFFFFFFF, 1, 32'h0, 1);
        xact("sel11_err", 0, 1, 2'b11, 0, 16'h0010, 32'h0, 1, 32'h0, 1);
        xact("wr_rd_err", 1, 1, 2'b10, 0, 16'h0010, 32'h0BADF00D, 1, 32'h0, 1);
        xact("lw_after_err", 0, 1, 2'b10, 0, 16'h0010, 32'h0, 4, 32'hA5223344, 0);

        // No-op
        xact("noop", 0, 0, 2'b10, 0, 16'h0010, 32'h0, 4, 32'h0, 0);

        // Backpressure with an ignored request during RESP
        rsp_ready = 1'b0;
        drive(0, 1, 2'b10, 0, 16'h0010, 32'h0);
        tick();
        req_valid = 1'b0;
        n = 1;
        while (!rsp_valid && n < 20) begin
            tick();
            n++;
        end
        chk("bp/latency", 32'(n), 32'd4);
        held = rsp_rdata;
        chk("bp/rdata", held, 32'hA5223344);
        drive(1, 0, 2'b10, 0, 16'h0010, 32'h00000099);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("bp/valid_held", 32'(rsp_valid), 32'd1);
            chk("bp/rdata_held", rsp_rdata, 32'hA5223344);
            chk("bp/ready_low", 32'(req_ready), 32'd0);
        end
        rsp_ready = 1'b1;
        req_valid = 1'b0;
        tick();
        chk("bp/ready_next", 32'(req_ready), 32'd1);
        chk("bp/valid_clear", 32'(rsp_valid), 32'd0);
        xact("bp/lw_check", 0, 1, 2'b10, 0, 16'h0010, 32'h0, 4, 32'hA5223344, 0);

        // Reset on the access edge of a store suppresses the write
        drive(1, 0, 2'b10, 0, 16'h0010, 32'hDEADBEEF);
        tick();
        req_valid = 1'b0;
        tick();
        tick();
        chk("rmid/busy_wait", 32'(busy), 32'd1);
        rst_n = 1'b0;
        tick();
        chk("rmid/valid", 32'(rsp_valid), 32'd0);
        chk("rmid/busy", 32'(busy), 32'd0);
        chk("rmid/ready_low", 32'(req_ready), 32'd0);
        rst_n = 1'b1;
        tick();
        chk("rmid/ready_high", 32'(req_ready), 32'd1);
        xact("rmid/lw_check", 0, 1, 2'b10, 0, 16'h0010, 32'h0, 4, 32'hA5223344, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
